mpu_i2c_master: RTL and testbench

//  I2C bus engine downstream of the MPU transaction sequencer (mpu_mid). Accepts one

---
 rtl/mpu_i2c_master.sv | 208 ++++++++++++++++++++
 tb/tb_mpu_i2c_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mpu_i2c_master                                               |
// | Description : I2C master frame engine: START, addr+W, n writes, optional   |
// |               Sr + addr+R + m reads, STOP. Returns read bytes one by one.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mpu_i2c_master #(
  parameter logic [6:0]  DEV_ADDR = 7'h68,
  parameter int unsigned CLK_DIV  = 62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_start,
  input  logic        rd_now,
  input  logic [2:0]  n,
  input  logic [2:0]  m,
  input  logic [15:0] data_packed,
  input  logic        sda_i,
  output logic        scl,
  output logic        sda_oe,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid
);

  localparam int unsigned            c_QCNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_QCNT_W-1:0]    c_QMAX   = c_QCNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_AW, S_WR_BYTE, S_ACK_WR, S_RSTART,
    S_ADDR_R, S_ACK_AR, S_RD_BYTE, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_QCNT_W-1:0]   r_qcnt;
  logic [1:0]            r_q;
  logic [2:0]            r_bit;
  logic                  r_rd_en;
  logic [1:0]            r_wr_left;
  logic                  r_wr_idx;
  logic [2:0]            r_rd_left;
  logic [15:0]           r_data;
  logic                  r_sda_smp;
  logic [6:0]            r_shift;
  logic                  r_sda_oe;
  logic                  r_ack_err;
  logic [7:0]            r_rd_data;
  logic                  r_rd_valid;

  logic                  w_active;
  logic                  w_q_end;
  logic                  w_slot_end;
  logic                  w_q1_go;
  logic                  w_q3_go;
  logic [7:0]            w_tx_byte;
  logic                  w_tx_bit;

  assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_q_end    = (r_qcnt == c_QMAX);
  assign w_slot_end = w_q_end && (r_q == 2'd3);
  assign w_q1_go    = w_q_end && (r_q == 2'd0);
  assign w_q3_go    = w_q_end && (r_q == 2'd2);

  always_comb begin
    w_tx_byte = {DEV_ADDR, 1'b0};
    case (r_state)
      S_ADDR_R:  w_tx_byte = {DEV_ADDR, 1'b1};
      S_WR_BYTE: w_tx_byte = r_wr_idx ? r_data[7:0] : r_data[15:8];
      default:   w_tx_byte = {DEV_ADDR, 1'b0};
    endcase
  end
  assign w_tx_bit = w_tx_byte[3'd7 - r_bit];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Transitions other than IDLE/DONE happen only on the last cycle of a slot
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (en_start) w_next = S_START;
      S_DONE: w_next = S_IDLE;
      default: begin
        if (w_slot_end) begin
          case (r_state)
            S_START:   w_next = S_ADDR_W;
            S_ADDR_W:  if (r_bit == 3'd7) w_next = S_ACK_AW;
            S_ACK_AW: begin
              if (r_sda_smp)              w_next = S_STOP;
              else if (r_wr_left != 2'd0) w_next = S_WR_BYTE;
              else if (r_rd_en)           w_next = S_RSTART;
              else                        w_next = S_STOP;
            end
            S_WR_BYTE: if (r_bit == 3'd7) w_next = S_ACK_WR;
            S_ACK_WR: begin
              if (r_sda_smp)              w_next = S_STOP;
              else if (r_wr_left > 2'd1)  w_next = S_WR_BYTE;
              else if (r_rd_en)           w_next = S_RSTART;
              else                        w_next = S_STOP;
            end
            S_RSTART:  w_next = S_ADDR_R;
            S_ADDR_R:  if (r_bit == 3'd7) w_next = S_ACK_AR;
            S_ACK_AR:  w_next = r_sda_smp ? S_STOP : S_RD_BYTE;
            S_RD_BYTE: if (r_bit == 3'd7) w_next = S_MACK;
            S_MACK:    w_next = (r_rd_left > 3'd1) ? S_RD_BYTE : S_STOP;
            S_STOP:    w_next = S_DONE;
            default:   w_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qcnt     <= '0;
      r_q        <= 2'd0;
      r_bit      <= 3'd0;
      r_rd_en    <= 1'b0;
      r_wr_left  <= 2'd0;
      r_wr_idx   <= 1'b0;
      r_rd_left  <= 3'd0;
      r_data     <= 16'h0000;
      r_sda_smp  <= 1'b1;
      r_shift    <= 7'd0;
      r_sda_oe   <= 1'b0;
      r_ack_err  <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (!w_active) begin
        r_qcnt   <= '0;
        r_q      <= 2'd0;
        r_bit    <= 3'd0;
        r_sda_oe <= 1'b0;
        if ((r_state == S_IDLE) && en_start) begin
          r_rd_en   <= rd_now && (m != 3'd0);
          r_wr_left <= (n > 3'd2) ? 2'd2 : n[1:0];
          r_wr_idx  <= 1'b0;
          r_rd_left <= m;
          r_data    <= data_packed;
          r_ack_err <= 1'b0;
        end
      end else begin
        if (w_q_end) begin
          r_qcnt <= '0;
          r_q    <= r_q + 2'd1;
        end else begin
          r_qcnt <= r_qcnt + 1'b1;
        end

        if (w_slot_end) begin
          if ((r_state == S_ADDR_W) || (r_state == S_WR_BYTE) ||
              (r_state == S_ADDR_R) || (r_state == S_RD_BYTE))
            r_bit <= r_bit + 3'd1;
          if (r_state == S_ACK_WR) begin
            r_wr_left <= r_wr_left - 2'd1;
            r_wr_idx  <= 1'b1;
          end
          if (r_state == S_MACK) r_rd_left <= r_rd_left - 3'd1;
        end

        // Data and ACK changes land at the start of q1, while SCL is low
        if (w_q1_go) begin
          case (r_state)
            S_START, S_RSTART, S_ACK_AW, S_ACK_WR, S_ACK_AR, S_RD_BYTE: r_sda_oe <= 1'b0;
            S_STOP:  r_sda_oe <= 1'b1;
            S_MACK:  r_sda_oe <= (r_rd_left > 3'd1);
            default: r_sda_oe <= ~w_tx_bit;
          endcase
        end

        // Last cycle of q2: sample the line; START/STOP edges go out in q3
        if (w_q3_go) begin
          r_sda_smp <= sda_i;
          if ((r_state == S_START) || (r_state == S_RSTART)) r_sda_oe <= 1'b1;
          if (r_state == S_STOP) r_sda_oe <= 1'b0;
          if (sda_i && ((r_state == S_ACK_AW) || (r_state == S_ACK_WR) || (r_state == S_ACK_AR)))
            r_ack_err <= 1'b1;
          if (r_state == S_RD_BYTE) begin
            r_shift <= {r_shift[5:0], sda_i};
            if (r_bit == 3'd7) begin
              r_rd_data  <= {r_shift, sda_i};
              r_rd_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign scl      = w_active ? r_q[1] : 1'b1;
  assign sda_oe   = r_sda_oe;
  assign busy     = w_active;
  assign done     = (r_state == S_DONE);
  assign ack_err  = r_ack_err;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_mpu_i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mpu_i2c_master                                            |
// | Description : Directed bench for mpu_i2c_master with an I2C slave model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mpu_i2c_master;

  logic        clk;
  logic        rst_n;
  logic        en_start;
  logic        rd_now;
  logic [2:0]  n;
  logic [2:0]  m;
  logic [15:0] data_packed;
  logic        sda_i;
  logic        scl;
  logic        sda_oe;
  logic        busy;
  logic        done;
  logic        ack_err;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int checks   = 0;
  int failures = 0;

  mpu_i2c_master #(.DEV_ADDR(7'h68), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_start(en_start), .rd_now(rd_now), .n(n), .m(m),
    .data_packed(data_packed), .sda_i(sda_i), .scl(scl), .sda_oe(sda_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull the line low
  logic slave_pull;
  assign sda_i = ~(sda_oe | slave_pull);

  // Slave model. Log codes: 0x100 START, 0x101 Sr, 0x102 STOP, 0x200|bit master ACK
  logic       ack_en;
  logic [7:0] rd_bytes [6];
  int         log_q [$];
  int         mode;
  logic [3:0] bit_cnt;
  logic [3:0] nxt_cnt;
  logic [7:0] shift;
  logic [7:0] tx;
  int         tx_idx;
  logic       go_read, skip_fall, m_ack, scl_d, sda_d;

  assign nxt_cnt = (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;

  always @(negedge clk) begin
    if (!rst_n) begin
      mode <= 0; slave_pull <= 1'b0; bit_cnt <= 4'd0; skip_fall <= 1'b0;
      go_read <= 1'b0; scl_d <= 1'b1; sda_d <= 1'b1; m_ack <= 1'b1;
    end else begin
      scl_d <= scl;
      sda_d <= sda_i;
      if (scl && scl_d && sda_d && !sda_i) begin
        log_q.push_back((mode == 0) ? 'h100 : 'h101);
        mode <= 1; bit_cnt <= 4'd0; skip_fall <= 1'b1; go_read <= 1'b0; slave_pull <= 1'b0;
      end else if (scl && scl_d && !sda_d && sda_i) begin
        log_q.push_back('h102);
        mode <= 0; slave_pull <= 1'b0;
      end else if (scl && !scl_d) begin
        if ((mode == 1 || mode == 2) && bit_cnt < 4'd8) shift <= {shift[6:0], sda_i};
        if (mode == 3 && bit_cnt == 4'd8) begin
          m_ack <= sda_i;
          log_q.push_back('h200 | int'(sda_i));
        end
      end else if (!scl && scl_d && mode != 0) begin
        if (skip_fall) skip_fall <= 1'b0;
        else begin
          bit_cnt <= nxt_cnt;
          if (mode == 1 || mode == 2) begin
            if (nxt_cnt == 4'd8) begin
              log_q.push_back(int'(shift));
              slave_pull <= ack_en;
              go_read <= (mode == 1) && shift[0];
            end else if (nxt_cnt == 4'd0) begin
              if (go_read && ack_en) begin
                mode <= 3; tx <= rd_bytes[0]; tx_idx <= 1; slave_pull <= ~rd_bytes[0][7];
              end else begin
                mode <= 2; slave_pull <= 1'b0;
              end
            end
          end else if (mode == 3) begin
            if (nxt_cnt == 4'd8) slave_pull <= 1'b0;
            else if (nxt_cnt == 4'd0) begin
              if (!m_ack && tx_idx < 6) begin
                tx <= rd_bytes[tx_idx]; tx_idx <= tx_idx + 1; slave_pull <= ~rd_bytes[tx_idx][7];
              end else begin
                mode <= 4; slave_pull <= 1'b0;
              end
            end else slave_pull <= ~tx[7 - nxt_cnt];
          end
        end
      end
    end
  end

  // Bus timing monitor: SCL half-periods of 4 cycles, SDA moves only at q1/q3 start
  int   run      = 0;
  int   tm_err   = 0;
  logic in_frame = 1'b0;
  logic oe_d     = 1'b0;
  logic scl_m    = 1'b1;

  always @(negedge clk) begin
    oe_d  <= sda_oe;
    scl_m <= scl;
    run   <= (scl != scl_m) ? 0 : run + 1;
    if (!busy) in_frame <= 1'b0;
    else if (scl != scl_m) begin
      if (in_frame && run != 3) tm_err <= tm_err + 1;
      in_frame <= 1'b1;
    end else if (sda_oe != oe_d && in_frame && run != 1) tm_err <= tm_err + 1;
  end

  logic [7:0] rd_q [$];

  task automatic send_cmd(input logic rd, input logic [2:0] nn, input logic [2:0] mm,
                          input logic [15:0] d);
    @(negedge clk);
    en_start = 1'b1; rd_now = rd; n = nn; m = mm; data_packed = d;
    @(negedge clk);
    en_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic ok);
    int guard;
    cyc = 0; guard = 0;
    rd_q.delete();
    while (!done && guard < 3000) begin
      if (busy) cyc++;
      if (rd_valid) rd_q.push_back(rd_data);
      @(negedge clk);
      guard++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (scl !== 1'b1)      begin failures++; $display("FAIL reset_scl got=%b exp=1", scl); end
    checks++; if (sda_oe !== 1'b0)   begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ack_err !== 1'b0)  begin failures++; $display("FAIL reset_ack_err got=%b exp=0", ack_err); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int cyc; logic ok;
    int exp_q [$] = '{'h100, 'hD0, 'h6B, 'h00, 'h102};
    log_q.delete();
    send_cmd(1'b0, 3'd2, 3'd0, 16'h6B00);
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL write_done_timeout got=%b exp=1", ok); end
    checks++; if (cyc < 230 || cyc > 234) begin failures++; $display("FAIL write_cycles got=%0d exp=232", cyc); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL write_ack_err got=%b exp=0", ack_err); end
    checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL write_rd_valid got=%0d exp=0", rd_q.size()); end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL write_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin failures++; $display("FAIL write_log[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL write_done_width got=%b exp=0", done); end
    checks++; if (tm_err != 0) begin failures++; $display("FAIL write_timing got=%0d exp=0", tm_err); end
  endtask

  task automatic test_read();
    int cyc; logic ok;
    int exp_q [$] = '{'h100, 'hD0, 'h3B, 'h101, 'hD1, 'h200, 'h200, 'h200, 'h200, 'h200, 'h201, 'h102};
    logic [7:0] exp_rd [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rd_bytes = exp_rd;
    log_q.delete();
    send_cmd(1'b1, 3'd1, 3'd6, 16'h3B00);
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL read_done_timeout got=%b exp=1", ok); end
    checks++; if (cyc < 670 || cyc > 674) begin failures++; $display("FAIL read_cycles got=%0d exp=672", cyc); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL read_ack_err got=%b exp=0", ack_err); end
    checks++; if (rd_q.size() != 6) begin failures++; $display("FAIL read_count got=%0d exp=6", rd_q.size()); end
    for (int i = 0; i < 6 && i < rd_q.size(); i++) begin
      checks++; if (rd_q[i] !== exp_rd[i]) begin failures++; $display("FAIL read_data[%0d] got=%h exp=%h", i, rd_q[i], exp_rd[i]); end
    end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL read_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin failures++; $display("FAIL read_log[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (tm_err != 0) begin failures++; $display("FAIL read_timing got=%0d exp=0", tm_err); end
  endtask

  task automatic test_nack();
    int cyc; logic ok; int extra;
    int exp_q [$] = '{'h100, 'hD0, 'h102};
    ack_en = 1'b0;
    log_q.delete();
    send_cmd(1'b0, 3'd2, 3'd0, 16'h1234);
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL nack_done_timeout got=%b exp=1", ok); end
    checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_ack_err got=%b exp=1", ack_err); end
    checks++; if (cyc < 86 || cyc > 90) begin failures++; $display("FAIL nack_cycles got=%0d exp=88", cyc); end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL nack_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin failures++; $display("FAIL nack_log[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL nack_done_once got=%0d exp=0", extra); end
    checks++; if (ack_err !== 1'b1) begin failures++; $display("FAIL nack_sticky got=%b exp=1", ack_err); end
    checks++; if (tm_err != 0) begin failures++; $display("FAIL nack_timing got=%0d exp=0", tm_err); end
    ack_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc; logic ok;
    int exp1 [$] = '{'h100, 'hD0, 'h6B, 'h00, 'h102};
    int exp2 [$] = '{'h100, 'hD0, 'hA5, 'hC3, 'h102};
    log_q.delete();
    send_cmd(1'b0, 3'd2, 3'd0, 16'h6B00);
    repeat (20) @(negedge clk);
    en_start = 1'b1; data_packed = 16'hFFFF; n = 3'd2;
    @(negedge clk);
    en_start = 1'b0;
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL guard_done_timeout got=%b exp=1", ok); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL guard_ack_err_cleared got=%b exp=0", ack_err); end
    checks++; if (log_q.size() != exp1.size()) begin failures++; $display("FAIL guard_log_len got=%0d exp=%0d", log_q.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp1[i]) begin failures++; $display("FAIL guard_log[%0d] got=%h exp=%h", i, log_q[i], exp1[i]); end
    end
    // Command in the cycle right after done; n=7 clamps to two bytes
    log_q.delete();
    send_cmd(1'b0, 3'd7, 3'd0, 16'hA5C3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_done_timeout got=%b exp=1", ok); end
    checks++; if (cyc < 230 || cyc > 234) begin failures++; $display("FAIL b2b_cycles got=%0d exp=232", cyc); end
    checks++; if (log_q.size() != exp2.size()) begin failures++; $display("FAIL b2b_log_len got=%0d exp=%0d", log_q.size(), exp2.size()); end
    for (int i = 0; i < exp2.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp2[i]) begin failures++; $display("FAIL b2b_log[%0d] got=%h exp=%h", i, log_q[i], exp2[i]); end
    end
    checks++; if (tm_err != 0) begin failures++; $display("FAIL b2b_timing got=%0d exp=0", tm_err); end
  endtask

  task automatic test_reset_mid_read();
    int cyc; logic ok; int seen; int guard;
    int exp_q [$] = '{'h100, 'hD0, 'h75, 'h102};
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_cmd(1'b1, 3'd1, 3'd6, 16'h3B00);
    seen = 0; guard = 0;
    while (seen < 2 && guard < 2000) begin
      if (rd_valid) seen++;
      @(negedge clk);
      guard++;
    end
    checks++; if (seen != 2) begin failures++; $display("FAIL midrst_two_bytes got=%0d exp=2", seen); end
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (scl !== 1'b1)      begin failures++; $display("FAIL midrst_scl got=%b exp=1", scl); end
    checks++; if (sda_oe !== 1'b0)   begin failures++; $display("FAIL midrst_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midrst_rd_data got=%h exp=00", rd_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
    send_cmd(1'b0, 3'd1, 3'd0, 16'h7500);
    wait_done(cyc, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL postrst_done_timeout got=%b exp=1", ok); end
    checks++; if (cyc < 158 || cyc > 162) begin failures++; $display("FAIL postrst_cycles got=%0d exp=160", cyc); end
    checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL postrst_ack_err got=%b exp=0", ack_err); end
    checks++; if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL postrst_log_len got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin failures++; $display("FAIL postrst_log[%0d] got=%h exp=%h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (tm_err != 0) begin failures++; $display("FAIL postrst_timing got=%0d exp=0", tm_err); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; en_start = 1'b0; rd_now = 1'b0; n = 3'd0; m = 3'd0;
    data_packed = 16'h0000; ack_en = 1'b1;
    rd_bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
